// File: rtl/layer_scheduler.sv
// layer_scheduler
// Sequences one frame through NUM_STAGES chained layer engines (conv, pool,
// dense, ...). Each engine is kicked with a one-cycle start pulse and the
// scheduler waits for that engine's done pulse before moving on. Consecutive
// stages use alternate halves of a ping-pong intermediate buffer. A per-stage
// watchdog moves the scheduler to ERR if an engine never answers.
//
// Handshake: start is a level sampled only in IDLE. Each engine sees a
// one-cycle stage_start pulse and answers with a one-cycle stage_done pulse.
// Only the done bit of the active stage is honoured, and only while waiting.
// The frame ends with a one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        frame request, honoured in IDLE only
//   abort        synchronous abort, returns to IDLE from any state
//   stage_done   per-engine done pulses
//   stage_start  one-hot, one-cycle start pulse per engine
//   cur_stage    index of the active stage
//   buf_sel      ping-pong buffer bank select
//   busy         high in every state except IDLE
//   done         one-cycle frame-complete pulse
//   error        high while in ERR
//   frame_count  completed frames, wraps at 16 bits
//   dbgState     current FSM state (IDLE=0 LAUNCH=1 WAIT=2 FINISH=3 ERR=4)
module layer_scheduler #(
   parameter int NUM_STAGES      = 3,
   parameter int STAGE_ADR_WIDTH = 2,
   parameter int TIMEOUT         = 1048575
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [NUM_STAGES-1:0]      stage_done,
   output logic [NUM_STAGES-1:0]      stage_start,
   output logic [STAGE_ADR_WIDTH-1:0] cur_stage,
   output logic                       buf_sel,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [15:0]                frame_count,
   output logic [2:0]                 dbgState
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      FINISH = 3'd3,
      ERR    = 3'd4
   } stateT;

   localparam logic [STAGE_ADR_WIDTH-1:0] LAST_STAGE = STAGE_ADR_WIDTH'(NUM_STAGES - 1);
   // The watchdog counts from 0, so reaching TIMEOUT-1 means TIMEOUT waited cycles.
   localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT - 1);
   localparam logic [NUM_STAGES-1:0] ONE_HOT_BASE = NUM_STAGES'(1);

   stateT       state;
   logic [19:0] watchdog;

   assign dbgState = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         stage_start <= '0;
         cur_stage   <= '0;
         buf_sel     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         frame_count <= 16'd0;
         watchdog    <= 20'd0;
      end else begin
         // Pulse outputs default low so each assertion lasts exactly one cycle.
         stage_start <= '0;
         done        <= 1'b0;

         if (abort) begin
            // Abort outranks every other event; the frame counter is kept.
            state     <= IDLE;
            cur_stage <= '0;
            buf_sel   <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            watchdog  <= 20'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     cur_stage <= '0;
                     buf_sel   <= 1'b0;
                     busy      <= 1'b1;
                     state     <= LAUNCH;
                  end
               end

               LAUNCH: begin
                  stage_start <= ONE_HOT_BASE << cur_stage;
                  watchdog    <= 20'd0;
                  state       <= WAIT;
               end

               WAIT: begin
                  // The active stage's done wins over a timeout in the same cycle.
                  if (stage_done[cur_stage]) begin
                     if (cur_stage == LAST_STAGE) begin
                        state <= FINISH;
                     end else begin
                        cur_stage <= cur_stage + 1'b1;
                        buf_sel   <= ~buf_sel;
                        state     <= LAUNCH;
                     end
                  end else if (watchdog == WD_LIMIT) begin
                     error <= 1'b1;
                     state <= ERR;
                  end else begin
                     watchdog <= watchdog + 20'd1;
                  end
               end

               FINISH: begin
                  done        <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end

               ERR: begin
                  // Parked until abort; cur_stage still names the stalled engine.
                  state <= ERR;
               end

               default: begin
                  busy  <= 1'b0;
                  error <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_scheduler.sv
module tb_layer_scheduler;

   localparam int NS = 3;
   localparam int SW = 2;
   localparam int TO = 8;
   localparam int W  = NS + 1 + SW;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LAUNCH = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_ERR    = 3'd4;

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          start      = 1'b0;
   logic          abort      = 1'b0;
   logic [NS-1:0] stage_done = '0;
   logic [NS-1:0] stage_start;
   logic [SW-1:0] cur_stage;
   logic          buf_sel;
   logic          busy;
   logic          done;
   logic          error;
   logic [15:0]   frame_count;
   logic [2:0]    dbgState;

   int nChecks = 0;
   int nFail   = 0;

   // Scoreboard: launch expectations {stage_start, buf_sel, cur_stage}
   // and the frame count expected at each done pulse.
   logic [W-1:0] expQ[$];
   logic [15:0]  expFcQ[$];
   logic [15:0]  fcModel = 16'd0;

   layer_scheduler #(
      .NUM_STAGES(NS),
      .STAGE_ADR_WIDTH(SW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .stage_done(stage_done),
      .stage_start(stage_start),
      .cur_stage(cur_stage),
      .buf_sel(buf_sel),
      .busy(busy),
      .done(done),
      .error(error),
      .frame_count(frame_count),
      .dbgState(dbgState)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushFrame(input int nStages);
      for (int i = 0; i < nStages; i++) begin
         logic [NS-1:0] oh;
         oh = NS'(1) << i;
         expQ.push_back({oh, 1'(i % 2), SW'(i)});
      end
   endtask

   task automatic startFrame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitPulse(input string tag);
      int cyc = 0;
      while (stage_start == '0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(stage_start != '0), 32'd1);
   endtask

   // Wait for the launch of stage idx, then answer delay cycles after it.
   task automatic doStage(input int idx, input int delay);
      waitPulse($sformatf("launch_seen_s%0d", idx));
      tick(delay - 1);
      stage_done = NS'(1) << idx;
      @(negedge clk);
      stage_done = '0;
   endtask

   task automatic waitDone(input string tag);
      int cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (stage_start != '0) begin
         if (expQ.size() == 0)
            check("spurious_launch", 32'(stage_start), 32'd0);
         else
            check("launch", 32'({stage_start, buf_sel, cur_stage}), 32'(expQ.pop_front()));
      end
      if (done) begin
         if (expFcQ.size() == 0)
            check("spurious_done", 32'(done), 32'd0);
         else
            check("done_frame_count", 32'(frame_count), 32'(expFcQ.pop_front()));
      end
   end

   // ---------------- global time limit ----------------
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      #2;
      check("rst_stage_start", 32'(stage_start), 32'd0);
      check("rst_cur_stage",   32'(cur_stage),   32'd0);
      check("rst_buf_sel",     32'(buf_sel),     32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_done",        32'(done),        32'd0);
      check("rst_error",       32'(error),       32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_state",       32'(dbgState),    32'(ST_IDLE));
      tick(2);
      rst = 1'b1;
      tick(1);

      // Nominal frame: each stage answers 5 cycles after its start pulse
      pushFrame(3);
      fcModel = fcModel + 16'd1;
      expFcQ.push_back(fcModel);
      startFrame();
      check("busy_after_start", 32'(busy), 32'd1);
      doStage(0, 5);
      doStage(1, 5);
      doStage(2, 5);
      waitDone("nominal_done");
      tick(1);
      check("nominal_busy_low", 32'(busy), 32'd0);
      check("nominal_fc", 32'(frame_count), 32'(fcModel));

      // Wrong-stage done is ignored, then stage 1 stalls into a timeout
      pushFrame(2);
      startFrame();
      waitPulse("wrong_stage_p0");
      stage_done = 3'b100;
      tick(1);
      stage_done = '0;
      tick(1);
      check("wrong_stage_hold_cur", 32'(cur_stage), 32'd0);
      check("wrong_stage_hold_state", 32'(dbgState), 32'(ST_WAIT));
      stage_done = 3'b001;
      tick(1);
      stage_done = '0;
      waitPulse("advance_p1");
      tick(TO - 1);
      check("no_early_error", 32'(error), 32'd0);
      tick(1);
      check("timeout_error", 32'(error), 32'd1);
      check("timeout_cur_stage", 32'(cur_stage), 32'd1);
      check("timeout_state", 32'(dbgState), 32'(ST_ERR));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      check("err_ignores_start", 32'(dbgState), 32'(ST_ERR));
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_error_low", 32'(error), 32'd0);
      check("abort_busy_low", 32'(busy), 32'd0);
      check("abort_cur_stage", 32'({cur_stage, buf_sel}), 32'd0);
      check("abort_fc_kept", 32'(frame_count), 32'(fcModel));

      // Abort and the active done in the same cycle: abort wins, no done
      pushFrame(1);
      startFrame();
      waitPulse("abort_race_p0");
      tick(1);
      abort = 1'b1;
      stage_done = 3'b001;
      tick(1);
      abort = 1'b0;
      stage_done = '0;
      check("abort_race_state", 32'(dbgState), 32'(ST_IDLE));
      check("abort_race_done", 32'(done), 32'd0);
      tick(3);
      check("abort_race_fc", 32'(frame_count), 32'(fcModel));

      // Timeout and done in the same cycle: done wins, frame completes
      pushFrame(3);
      fcModel = fcModel + 16'd1;
      expFcQ.push_back(fcModel);
      startFrame();
      waitPulse("tmo_race_p0");
      tick(TO - 1);
      stage_done = 3'b001;
      tick(1);
      stage_done = '0;
      check("tmo_race_no_error", 32'(error), 32'd0);
      check("tmo_race_advance", 32'(dbgState), 32'(ST_LAUNCH));
      doStage(1, 5);
      doStage(2, 5);
      waitDone("tmo_race_done");

      // Asynchronous reset in stage 2 WAIT, then a stale done after release
      pushFrame(3);
      startFrame();
      doStage(0, 3);
      doStage(1, 3);
      waitPulse("rst_mid_p2");
      tick(1);
      #2 rst = 1'b0;
      #1;
      check("arst_outputs", 32'({stage_start, cur_stage, buf_sel, busy, done, error}), 32'd0);
      check("arst_fc", 32'(frame_count), 32'd0);
      check("arst_state", 32'(dbgState), 32'(ST_IDLE));
      fcModel = 16'd0;
      @(negedge clk);
      rst = 1'b1;
      stage_done = 3'b100;
      tick(1);
      stage_done = '0;
      tick(3);
      check("stale_done_ignored", 32'({busy, dbgState}), 32'(ST_IDLE));

      // Frame counter wrap, with a start issued while busy
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      fcModel = 16'hFFFF;
      check("fc_preload", 32'(frame_count), 32'(fcModel));
      pushFrame(3);
      fcModel = fcModel + 16'd1;
      expFcQ.push_back(fcModel);
      startFrame();
      waitPulse("wrap_p0");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      stage_done = 3'b001;
      tick(1);
      stage_done = '0;
      doStage(1, 5);
      doStage(2, 5);
      waitDone("wrap_done");
      tick(10);
      check("wrap_fc_zero", 32'(frame_count), 32'(fcModel));
      check("wrap_no_requeue", 32'(busy), 32'd0);

      // Final report
      check("launch_queue_drained", 32'(expQ.size()), 32'd0);
      check("done_queue_drained", 32'(expFcQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
